jtgng_ram_rdstream: RTL and testbench

Read-side streaming engine for the simple dual-port RAM (dw-bit words, aw-bit address, registered read port with one-clock latency). On a start command it reads a block of consecutive words from the RAM read port and delivers them, in address order, on a valid/ready output stream. A two-entry skid FIFO absorbs the RAM latency, so back-pressure never drops or duplicates a word. It sits between a buffer filled by a CPU or DMA writer and a consumer such as a sound, sprite or line-buffer engine.

---
 rtl/jtgng_ram_rdstream.sv | 110 +++++++++++
 tb/tb_jtgng_ram_rdstream.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/jtgng_ram_rdstream.sv
// Streams a block of consecutive RAM words onto a valid/ready interface.
// A two-entry skid FIFO absorbs the one-clock RAM read latency under back-pressure.
module jtgng_ram_rdstream #(
   parameter int dw = 8,
   parameter int aw = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [aw-1:0] base_addr,
   input  logic [aw-1:0] len,
   input  logic          abort,
   output logic [aw-1:0] ram_addr,
   input  logic [dw-1:0] ram_q,
   output logic [dw-1:0] dout,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state, state_nx;
   logic [aw-1:0] len_r;
   logic [aw:0]   issue_cnt, pop_cnt;
   logic          rd_pend;
   logic [dw-1:0] fifo [2];
   logic          wr_ptr, rd_ptr;
   logic [1:0]    fifo_cnt;
   logic          pop, issue, last_issue, last_pop, accept, flush;

   assign dout_valid = (fifo_cnt != 2'd0);
   assign dout       = fifo[rd_ptr];
   assign busy       = (state != IDLE);
   assign pop        = dout_valid & dout_ready;
   assign accept     = (state == IDLE) & start & ~abort;
   assign flush      = (state != IDLE) & abort;

   // Count the in-flight word and credit this cycle's pop so reads resume immediately.
   assign issue      = (state == RUN) && !abort &&
                       (({1'b0, fifo_cnt} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop}));
   assign last_issue = issue && (issue_cnt == {1'b0, len_r});
   assign last_pop   = pop && (state == DRAIN) && !abort && (pop_cnt == {1'b0, len_r});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (abort) state_nx = IDLE;
                  else if (last_issue) state_nx = DRAIN;
         DRAIN:   if (abort || last_pop) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_r     <= '0;
         ram_addr  <= '0;
         issue_cnt <= '0;
         pop_cnt   <= '0;
         rd_pend   <= 1'b0;
         done      <= 1'b0;
      end else begin
         rd_pend <= issue;
         done    <= last_pop;
         if (accept) begin
            len_r     <= len;
            ram_addr  <= base_addr;
            issue_cnt <= '0;
            pop_cnt   <= '0;
         end else begin
            if (issue) begin
               ram_addr  <= ram_addr + aw'(1);
               issue_cnt <= issue_cnt + (aw+1)'(1);
            end
            if (pop) pop_cnt <= pop_cnt + (aw+1)'(1);
         end
      end
   end

   // Skid FIFO: rd_pend marks ram_q as holding a word to capture this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo[0]  <= '0;
         fifo[1]  <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else if (flush) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (rd_pend) begin
            fifo[wr_ptr] <= ram_q;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_jtgng_ram_rdstream.sv
// Directed + randomized bench for jtgng_ram_rdstream with a behavioural RAM and
// an expected-word queue built from base/len with modulo-2**aw addressing.
module tb_jtgng_ram_rdstream;

   logic       clk = 1'b0;
   logic       rst_n, start, abort, dout_ready;
   logic [9:0] base_addr, len, ram_addr;
   logic [7:0] ram_q, dout;
   logic       dout_valid, busy, done;
   logic [7:0] mem [1024];
   int         n_chk = 0, n_fail = 0;

   jtgng_ram_rdstream #(.dw(8), .aw(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
      .abort(abort), .ram_addr(ram_addr), .ram_q(ram_q), .dout(dout),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ram_q <= mem[ram_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_random();
      for (int k = 0; k < 1024; k++) mem[k] = 8'($urandom);
   endtask

   // Cycle-exact check of the documented timing for base=0x010, len=7.
   task automatic rate_test();
      for (int k = 0; k < 1024; k++) mem[k] = 8'(k);
      dout_ready = 1'b1;
      base_addr  = 10'h010;
      len        = 10'd7;
      start      = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         chk("rate_busy",  32'(busy),       32'(c >= 1 && c <= 10));
         chk("rate_done",  32'(done),       32'(c == 11));
         chk("rate_valid", 32'(dout_valid), 32'(c >= 3 && c <= 10));
         if (c >= 3 && c <= 10) chk("rate_dout", 32'(dout), 32'(16 + c - 3));
         tick();
      end
   endtask

   // mode 0: ready always high; mode 1: random ready with a 10-cycle low stretch.
   task automatic run_xfer(input logic [9:0] b, input logic [9:0] l, input int mode,
                           input bit extra_start);
      logic [7:0] q[$];
      logic [7:0] pd = '0;
      bit         pv = 0, pr = 0, last_prev = 0, last_now, seen_done = 0;
      int         cyc;
      for (int k = 0; k <= int'(l); k++) q.push_back(mem[(int'(b) + k) % 1024]);
      base_addr = b;
      len       = l;
      start     = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 1;
      while (cyc < 4000 && !seen_done) begin
         if (mode == 0)                 dout_ready = 1'b1;
         else if (cyc >= 5 && cyc < 15) dout_ready = 1'b0;
         else                           dout_ready = 1'($urandom_range(0, 1));
         if (extra_start && cyc == 6) begin
            start     = 1'b1;
            base_addr = ~b;
            len       = 10'd3;
         end else start = 1'b0;
         if (pv && !pr) begin
            chk("hold_valid", 32'(dout_valid), 32'd1);
            chk("hold_dout",  32'(dout),       32'(pd));
         end
         if (dut.fifo_cnt > 2'd2) chk("fifo_cnt", 32'(dut.fifo_cnt), 32'd2);
         last_now = 0;
         if (done) begin
            seen_done = 1;
            chk("done_after_last", 32'(last_prev), 32'd1);
            chk("done_busy",       32'(busy),      32'd0);
         end else if (dout_valid && dout_ready) begin
            if (q.size() == 0) chk("extra_word", 32'(dout), 32'hFFFF);
            else begin
               chk("xfer_dout", 32'(dout), 32'(q.pop_front()));
               last_now = (q.size() == 0);
            end
         end
         pv = dout_valid; pr = dout_ready; pd = dout; last_prev = last_now;
         if (!seen_done) begin
            tick();
            cyc++;
         end
      end
      start = 1'b0;
      chk("done_seen",  32'(seen_done), 32'd1);
      chk("words_left", 32'(q.size()),  32'd0);
      tick();
      chk("done_one_clk", 32'(done), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; dout_ready = 1'b0;
      base_addr = '0; len = '0;
      fill_random();
      #12;
      chk("rst_ram_addr", 32'(ram_addr),   32'd0);
      chk("rst_dout",     32'(dout),       32'd0);
      chk("rst_valid",    32'(dout_valid), 32'd0);
      chk("rst_busy",     32'(busy),       32'd0);
      chk("rst_done",     32'(done),       32'd0);
      rst_n = 1'b1;
      tick();

      rate_test();

      fill_random();
      run_xfer(10'h3FE, 10'd3, 0, 0);

      run_xfer(10'($urandom), 10'd15, 1, 0);
      run_xfer(10'($urandom), 10'd15, 1, 0);

      fill_random();
      run_xfer(10'($urandom), 10'h3FF, 0, 1);

      // Abort in cycle 4 of an 8-word transfer.
      fill_random();
      dout_ready = 1'b1;
      base_addr  = 10'h100;
      len        = 10'd7;
      start      = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 4; c++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy",  32'(busy),       32'd0);
      chk("abort_valid", 32'(dout_valid), 32'd0);
      for (int c = 0; c < 6; c++) begin
         chk("abort_no_done",  32'(done),       32'd0);
         chk("abort_no_valid", 32'(dout_valid), 32'd0);
         tick();
      end
      fill_random();
      run_xfer(10'h104, 10'd7, 1, 0);

      // Reset asserted in cycle 5 of a transfer.
      dout_ready = 1'b1;
      base_addr  = 10'h020;
      len        = 10'd7;
      start      = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 5; c++) tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ram_addr", 32'(ram_addr),   32'd0);
      chk("mid_rst_dout",     32'(dout),       32'd0);
      chk("mid_rst_valid",    32'(dout_valid), 32'd0);
      chk("mid_rst_busy",     32'(busy),       32'd0);
      chk("mid_rst_done",     32'(done),       32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      rate_test();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
